alu_arbiter: RTL and testbench

Shares the single 32-bit combinational ALU between two requesters (fetch/address path on port 0, execute path on port 1) using round-robin arbitration, valid/ready handshakes and a registered result path. One operation is in flight at a time. Operands are captured on acceptance, evaluated in a dedicated execute cycle, and held on the winner's response port until it is consumed.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 32 +++
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, select encoding and arbiter FSM states
//
// Purpose : common definitions for the ALU and the ALU arbiter.
// Contents: WIDTH           operand/result width (fixed at 32)
//           ALU_* selects   3-bit operation codes
//           state_t         2-bit arbiter FSM encoding
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational ALU
//
// Purpose : AND, OR, ADD, SUB, unsigned set-less-than; unused codes give 0.
// Ports   : A, B     in  WIDTH  operands
//           ALU_Sel  in  3      operation select (alu_pkg encoding)
//           R        out WIDTH  result
//           ZFlag    out 1      high when R is zero
module alu
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] R,
  output logic             ZFlag
);

  always_comb begin
    R = '0;
    case (ALU_Sel)
      ALU_AND: R = A & B;
      ALU_OR:  R = A | B;
      ALU_ADD: R = A + B;
      ALU_SUB: R = A - B;
      ALU_SLT: R = {{(WIDTH-1){1'b0}}, (A < B)};
      default: R = '0;
    endcase
  end

  assign ZFlag = (R == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
//
// Purpose : two valid/ready request ports share a single ALU. One operation
//           is in flight at a time: accept in IDLE, evaluate in EXEC, hold
//           the registered result in RESP until the owner consumes it.
// Ports   : clk                    in  1      rising-edge clock
//           reset                  in  1      async active-high reset
//           reqN_valid/reqN_ready  in/out 1   request handshake, N = 0,1
//           reqN_a, reqN_b         in  WIDTH  operands
//           reqN_sel               in  3      operation select
//           rspN_valid/rspN_ready  out/in 1   response handshake
//           rsp_result             out WIDTH  registered result (shared)
//           rsp_zero               out 1      registered zero flag
//           busy                   out 1      high in EXEC or RESP
module alu_arbiter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,

  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  state_t           state, state_next;
  logic             last_grant;
  logic             owner;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       op_sel;

  logic             grant;
  logic             grant_valid;
  logic             accept;
  logic             rsp_done;

  logic [WIDTH-1:0] alu_r;
  logic             alu_z;

  // Round-robin: a lone valid wins outright; on a tie the requester that
  // did not win last time goes next. last_grant resets to 1 so port 0
  // takes the first tie.
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    if (req0_valid && req1_valid) begin
      grant       = ~last_grant;
      grant_valid = 1'b1;
    end else if (req0_valid) begin
      grant       = 1'b0;
      grant_valid = 1'b1;
    end else if (req1_valid) begin
      grant       = 1'b1;
      grant_valid = 1'b1;
    end
  end

  assign req0_ready = (state == ST_IDLE) && grant_valid && (grant == 1'b0);
  assign req1_ready = (state == ST_IDLE) && grant_valid && (grant == 1'b1);
  assign accept     = req0_ready || req1_ready;

  assign rsp0_valid = (state == ST_RESP) && (owner == 1'b0);
  assign rsp1_valid = (state == ST_RESP) && (owner == 1'b1);
  assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign busy = (state == ST_EXEC) || (state == ST_RESP);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)   state_next = ST_EXEC;
      ST_EXEC:               state_next = ST_RESP;
      ST_RESP: if (rsp_done) state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture on accept; the winner's payload is muxed in here so
  // the ALU only ever sees the latched copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= ALU_AND;
    end else if (accept) begin
      last_grant <= grant;
      owner      <= grant;
      op_a       <= grant ? req1_a   : req0_a;
      op_b       <= grant ? req1_b   : req0_b;
      op_sel     <= grant ? req1_sel : req0_sel;
    end
  end

  alu u_alu (
    .A       (op_a),
    .B       (op_b),
    .ALU_Sel (op_sel),
    .R       (alu_r),
    .ZFlag   (alu_z)
  );

  // Result registers load only at the end of EXEC, so they stay stable for
  // the whole of RESP regardless of backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_result <= alu_r;
      rsp_zero   <= alu_z;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed table-driven bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  s0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [2:0]  s1;
    logic        g;
    logic [31:0] res;
    logic        z;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [2:0] s0, input logic v1, input logic [31:0] a1,
                              input logic [31:0] b1, input logic [2:0] s1, input logic g,
                              input logic [31:0] res, input logic z);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.s0 = s0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.s1 = s1;
    v.g = g; v.res = res; v.z = z;
    return v;
  endfunction

  // Entered just after a negedge; returns just after a negedge with the
  // DUT back in IDLE.
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_sel = v.s0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_sel = v.s1;
    #1;
    chk($sformatf("v%0d req0_ready", i), {31'b0, req0_ready}, {31'b0, ~v.g});
    chk($sformatf("v%0d req1_ready", i), {31'b0, req1_ready}, {31'b0, v.g});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d exec busy", i), {31'b0, busy}, 32'd1);
    chk($sformatf("v%0d exec rspv", i), {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d rsp0_valid", i), {31'b0, rsp0_valid}, {31'b0, ~v.g});
    chk($sformatf("v%0d rsp1_valid", i), {31'b0, rsp1_valid}, {31'b0, v.g});
    chk($sformatf("v%0d result", i), rsp_result, v.res);
    chk($sformatf("v%0d zero", i), {31'b0, rsp_zero}, {31'b0, v.z});
    if (v.g) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d idle busy", i), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Ties first after reset so the reset value of last_grant is exercised.
    vecs[0]  = mk(1, 32'd7,  32'd7,  3'b110, 1, 32'hF0, 32'h0F, 3'b000, 0, 32'd0, 1);
    vecs[1]  = mk(1, 32'd7,  32'd7,  3'b110, 1, 32'hF0, 32'h0F, 3'b000, 1, 32'd0, 1);
    vecs[2]  = mk(1, 32'd1,  32'd2,  3'b010, 1, 32'd9,  32'd9,  3'b001, 0, 32'd3, 0);
    vecs[3]  = mk(1, 32'd1,  32'd2,  3'b010, 1, 32'd10, 32'd3,  3'b110, 1, 32'd7, 0);
    vecs[4]  = mk(1, 32'd0,  32'd1,  3'b111, 1, 32'd10, 32'd3,  3'b110, 0, 32'd1, 0);
    vecs[5]  = mk(1, 32'd0,  32'd1,  3'b111, 1, 32'h80000000, 32'h80000000, 3'b010, 1, 32'd0, 1);
    vecs[6]  = mk(1, 32'd5,  32'd3,  3'b010, 0, 32'd0,  32'd0,  3'b000, 0, 32'd8, 0);
    vecs[7]  = mk(1, 32'hFFFFFFFF, 32'd1, 3'b010, 0, 32'd0, 32'd0, 3'b000, 0, 32'd0, 1);
    vecs[8]  = mk(0, 32'd0,  32'd0,  3'b000, 1, 32'd0,  32'd1,  3'b110, 1, 32'hFFFFFFFF, 0);
    vecs[9]  = mk(1, 32'd5,  32'd3,  3'b101, 0, 32'd0,  32'd0,  3'b000, 0, 32'd0, 1);
    vecs[10] = mk(0, 32'd0,  32'd0,  3'b000, 1, 32'hF0, 32'h0F, 3'b001, 1, 32'hFF, 0);
    vecs[11] = mk(1, 32'd3,  32'd5,  3'b111, 0, 32'd0,  32'd0,  3'b000, 0, 32'd1, 0);
    vecs[12] = mk(0, 32'd0,  32'd0,  3'b000, 1, 32'd5,  32'd3,  3'b111, 1, 32'd0, 1);

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_a = '0; req1_b = '0; req1_sel = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset rspv", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("reset result", rsp_result, 32'd0);
    chk("reset zero", {31'b0, rsp_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle no valid readies", {30'b0, req1_ready, req0_ready}, 32'd0);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Backpressure on port 1 while port 0 waits with a stable request.
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'hFFFFFFFF; req1_sel = 3'b111;
    #1;
    chk("bp req1_ready", {31'b0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_sel = 3'b010;
    @(negedge clk);
    chk("bp exec req0_ready", {31'b0, req0_ready}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d rsp1_valid", k), {31'b0, rsp1_valid}, 32'd1);
      chk($sformatf("bp%0d result", k), rsp_result, 32'd1);
      chk($sformatf("bp%0d zero", k), {31'b0, rsp_zero}, 32'd0);
      chk($sformatf("bp%0d req0_ready", k), {31'b0, req0_ready}, 32'd0);
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    chk("bp release req0_ready", {31'b0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    @(negedge clk);
    chk("bp idle busy", {31'b0, busy}, 32'd0);
    chk("bp idle rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("bp idle req0_ready", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp port0 rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("bp port0 result", rsp_result, 32'd4);
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    @(negedge clk);

    // Reset during EXEC; last_grant is 0 beforehand so a restored value is visible.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_sel = 3'b010;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("rst_exec busy before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_exec busy", {31'b0, busy}, 32'd0);
    chk("rst_exec result", rsp_result, 32'd0);
    @(negedge clk);
    chk("rst_exec rspv", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_exec no rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_exec tie req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("rst_exec tie req1_ready", {31'b0, req1_ready}, 32'd0);

    // That tie is accepted (port 0), then reset lands in RESP.
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_resp rsp0_valid before", {31'b0, rsp0_valid}, 32'd1);
    chk("rst_resp result before", rsp_result, 32'd2);
    reset = 1'b1;
    #1;
    chk("rst_resp rspv", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_resp busy", {31'b0, busy}, 32'd0);
    chk("rst_resp result", rsp_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_resp tie req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("rst_resp tie req1_ready", {31'b0, req1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
